countdown_ctrl: RTL and testbench

- Sequencing controller for the 3-bit down counter + 7-segment display path on the DE1 board.
- Replaces the divided-clock scheme: one system clock, with a single-cycle tick enable from an internal prescaler.
- Runs a start/pause/load FSM around a WIDTH-bit down counter. `count` feeds the existing 7-segment decoder unchanged.

---
 rtl/countdown_pkg.sv | 22 ++
 rtl/countdown_ctrl_tick_gen.sv | 34 +++
 rtl/countdown_ctrl.sv | 123 ++++++++++++
 tb/tb_countdown_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// rtl/countdown_pkg.sv - shared state encoding and divider helpers for countdown_ctrl
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_CLK_HZ  = 50000000;
    localparam int DEF_TICK_HZ = 1;

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    function automatic int div_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/countdown_ctrl_tick_gen.sv
// rtl/countdown_ctrl_tick_gen.sv - prescaler producing a one-cycle tick every DIV enabled cycles
module tick_gen
    import countdown_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = div_width(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    if (DIV < 2) begin : g_div_check
        $error("tick_gen: DIV must be >= 2");
    end

    logic [W-1:0] cnt;

    // Holds its value while disabled so a paused count resumes mid-period.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/countdown_ctrl.sv
// rtl/countdown_ctrl.sv - start/pause/load countdown FSM; COUNTDOWN_AUTO_RELOAD_EN enables wrap-around reload
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int CLK_HZ  = DEF_CLK_HZ,
    parameter int TICK_HZ = DEF_TICK_HZ,
    parameter int WIDTH   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       state_o,
    output logic             busy,
    output logic             done,
    output logic             tick_o
);

    localparam int DIV = calc_div(CLK_HZ, TICK_HZ);

    state_t           state, state_n;
    logic [WIDTH-1:0] count_n;
    logic             done_n;
    logic             presc_clr;
    logic             tick;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload, reload_n;
`endif

    tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (state == RUN),
        .clr   (presc_clr),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '1;
            done   <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload <= '1;
`endif
        end else begin
            state  <= state_n;
            count  <= count_n;
            done   <= done_n;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload <= reload_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        count_n   = count;
        done_n    = 1'b0;
        presc_clr = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        reload_n  = reload;
`endif
        if (load) begin
            state_n   = IDLE;
            count_n   = load_val;
            presc_clr = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_n  = load_val;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            state_n   = RUN;
                            presc_clr = 1'b1;
                        end else begin
                            state_n = DONE;
                            done_n  = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_n = PAUSE;
                    end
                    // Reaching zero overrides a simultaneous pause in the stopping build.
                    if (tick) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        if (count == '0) begin
                            count_n = reload;
                        end else begin
                            count_n = count - WIDTH'(1);
                            done_n  = (count == WIDTH'(1));
                        end
`else
                        count_n = count - WIDTH'(1);
                        if (count == WIDTH'(1)) begin
                            done_n  = 1'b1;
                            state_n = DONE;
                        end
`endif
                    end
                end
                PAUSE: begin
                    if (start) begin
                        state_n = RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state_o = state;
    assign busy    = (state == RUN) || (state == PAUSE);
    assign tick_o  = tick;

endmodule

// File: tb/tb_countdown_ctrl.sv
// tb/tb_countdown_ctrl.sv - scoreboard bench for countdown_ctrl with CLK_HZ=4, TICK_HZ=1, WIDTH=3
module tb_countdown_ctrl;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset, start, pause, load;
    logic [2:0] load_val;
    logic [2:0] count;
    logic [1:0] state_o;
    logic       busy, done, tick_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0] count;
        logic [1:0] state;
        logic       done;
        logic       tick;
        logic       busy;
    } exp_t;

    exp_t sb[$];

    logic [1:0] m_state;
    logic [2:0] m_count, m_reload;
    int         m_presc;

    countdown_ctrl #(.CLK_HZ(4), .TICK_HZ(1), .WIDTH(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .pause    (pause),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .state_o  (state_o),
        .busy     (busy),
        .done     (done),
        .tick_o   (tick_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (count !== e.count || state_o !== e.state || done !== e.done ||
                tick_o !== e.tick || busy !== e.busy) begin
                errors++;
                $display("FAIL scoreboard t=%0t count=%0d/%0d state=%0d/%0d done=%0b/%0b tick=%0b/%0b busy=%0b/%0b",
                         $time, count, e.count, state_o, e.state, done, e.done,
                         tick_o, e.tick, busy, e.busy);
            end
        end
    end

    // Reference model advanced once per clock using the inputs about to be sampled.
    task automatic cyc();
        logic [1:0] ns;
        logic [2:0] nc, nr;
        int         np;
        logic       nd;
        bit         auto_rl;
        exp_t       e;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        auto_rl = 1'b1;
`else
        auto_rl = 1'b0;
`endif
        ns = m_state; nc = m_count; nr = m_reload; np = m_presc; nd = 1'b0;
        if (reset) begin
            ns = 2'd0; nc = 3'd7; nr = 3'd7; np = 0;
        end else if (load) begin
            ns = 2'd0; nc = load_val; nr = load_val; np = 0;
        end else if (m_state == 2'd0) begin
            if (start && m_count == 3'd0) begin
                ns = 2'd3; nd = 1'b1;
            end else if (start) begin
                ns = 2'd1; np = 0;
            end
        end else if (m_state == 2'd1) begin
            np = (m_presc == DIV - 1) ? 0 : m_presc + 1;
            if (pause) ns = 2'd2;
            if (m_presc == DIV - 1) begin
                if (auto_rl && m_count == 3'd0) begin
                    nc = m_reload;
                end else begin
                    nc = m_count - 3'd1;
                    if (nc == 3'd0) begin
                        nd = 1'b1;
                        if (!auto_rl) ns = 2'd3;
                    end
                end
            end
        end else if (m_state == 2'd2) begin
            if (start) ns = 2'd1;
        end
        m_state = ns; m_count = nc; m_reload = nr; m_presc = np;
        e.count = nc;
        e.state = ns;
        e.done  = nd;
        e.tick  = (ns == 2'd1) && (np == DIV - 1);
        e.busy  = (ns == 2'd1) || (ns == 2'd2);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; pause = 1'b0; load = 1'b0; load_val = 3'd0;
        m_state = 2'd0; m_count = 3'd7; m_reload = 3'd7; m_presc = 0;
        cyc();
        cyc();
        reset = 1'b0;
        checks++; if (count !== 3'd7)    begin errors++; $display("FAIL reset_count got %0d want 7", count); end
        checks++; if (state_o !== 2'd0)  begin errors++; $display("FAIL reset_state got %0d want 0", state_o); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got %0b want 0", done); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (tick_o !== 1'b0)   begin errors++; $display("FAIL reset_tick got %0b want 0", tick_o); end
    endtask

    task automatic test_countdown();
        int first_change = -1;
        int done_at = -1;
        int dones = 0;
        int last_change = 1;
        int bad_interval = 0;
        logic [2:0] prev;
        start = 1'b1;
        cyc();
        start = 1'b0;
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL cd_run got %0d want 1", state_o); end
        prev = count;
        for (int k = 2; k <= 40; k++) begin
            cyc();
            if (count !== prev) begin
                if (first_change < 0) first_change = k;
                else if (k - last_change != DIV) bad_interval++;
                last_change = k;
                prev = count;
            end
            if (done === 1'b1) begin
                dones++;
                done_at = k;
            end
        end
        checks++; if (first_change != 5) begin errors++; $display("FAIL cd_first_dec got %0d want 5", first_change); end
        checks++; if (bad_interval != 0) begin errors++; $display("FAIL cd_interval got %0d bad want 0", bad_interval); end
        checks++; if (dones != 1)        begin errors++; $display("FAIL cd_done_pulses got %0d want 1", dones); end
        checks++; if (done_at != 29)     begin errors++; $display("FAIL cd_done_cycle got %0d want 29", done_at); end
        checks++; if (count !== 3'd0)    begin errors++; $display("FAIL cd_final_count got %0d want 0", count); end
        checks++; if (state_o !== 2'd3)  begin errors++; $display("FAIL cd_final_state got %0d want 3", state_o); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL cd_final_busy got %0b want 0", busy); end
    endtask

    task automatic test_load_mid_run();
        load = 1'b1; load_val = 3'd7; cyc(); load = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        for (int k = 0; k < 6; k++) cyc();
        load = 1'b1; load_val = 3'd3; cyc(); load = 1'b0;
        checks++; if (count !== 3'd3)   begin errors++; $display("FAIL ld_count got %0d want 3", count); end
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL ld_state got %0d want 0", state_o); end
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc(); cyc();
        checks++; if (count !== 3'd3)   begin errors++; $display("FAIL ld_before_tick got %0d want 3", count); end
        cyc();
        checks++; if (count !== 3'd2)   begin errors++; $display("FAIL ld_first_dec got %0d want 2", count); end
    endtask

    task automatic test_pause_resume();
        int guard = 0;
        load = 1'b1; load_val = 3'd7; cyc(); load = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        while (!(m_count == 3'd5 && m_presc == 2) && guard < 50) begin
            cyc();
            guard++;
        end
        checks++; if (guard >= 50) begin errors++; $display("FAIL pz_reach_point got timeout want count5/presc2"); end
        pause = 1'b1;
        for (int k = 0; k < 10; k++) cyc();
        pause = 1'b0;
        checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL pz_state got %0d want 2", state_o); end
        checks++; if (count !== 3'd5)   begin errors++; $display("FAIL pz_count got %0d want 5", count); end
        start = 1'b1; cyc(); start = 1'b0;
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL pz_resume got %0d want 1", state_o); end
        checks++; if (count !== 3'd5)   begin errors++; $display("FAIL pz_resume_count got %0d want 5", count); end
        cyc();
        checks++; if (count !== 3'd4)   begin errors++; $display("FAIL pz_next_dec got %0d want 4", count); end
    endtask

    task automatic test_zero_load();
        load = 1'b1; load_val = 3'd0; cyc(); load = 1'b0;
        start = 1'b1; cyc();
        checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL zl_state got %0d want 3", state_o); end
        checks++; if (done !== 1'b1)    begin errors++; $display("FAIL zl_done got %0b want 1", done); end
        checks++; if (count !== 3'd0)   begin errors++; $display("FAIL zl_count got %0d want 0", count); end
        pause = 1'b1;
        for (int k = 0; k < 6; k++) cyc();
        start = 1'b0; pause = 1'b0;
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL zl_done_once got %0b want 0", done); end
        checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL zl_hold got %0d want 3", state_o); end
    endtask

    task automatic test_reset_mid_run();
        load = 1'b1; load_val = 3'd6; cyc(); load = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        for (int k = 0; k < 7; k++) cyc();
        reset = 1'b1; cyc(); reset = 1'b0;
        checks++; if (count !== 3'd7)   begin errors++; $display("FAIL rm_count got %0d want 7", count); end
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL rm_state got %0d want 0", state_o); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL rm_done got %0b want 0", done); end
        checks++; if (tick_o !== 1'b0)  begin errors++; $display("FAIL rm_tick got %0b want 0", tick_o); end
    endtask

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    task automatic test_auto_reload();
        int dones = 0;
        int left_run = 0;
        load = 1'b1; load_val = 3'd2; cyc(); load = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        for (int k = 2; k <= 30; k++) begin
            cyc();
            if (done === 1'b1) dones++;
            if (state_o !== 2'd1) left_run++;
        end
        checks++; if (dones != 2)    begin errors++; $display("FAIL ar_dones got %0d want 2", dones); end
        checks++; if (left_run != 0) begin errors++; $display("FAIL ar_left_run got %0d want 0", left_run); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL ar_count got %0d want 1", count); end
    endtask
`endif

    initial begin
        test_reset();
        test_countdown();
        test_load_mid_run();
        test_pause_resume();
        test_zero_load();
        test_reset_mid_run();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        test_auto_reload();
`endif
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
